// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: runs one EXU memory request at a time as an AXI4-Lite
// master transaction and returns the result on a valid/ready response channel.
module ysyx_23060208_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // request from execute stage
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [REG_WIDTH-1:0]  req_rd,
    // response toward write-back
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [REG_WIDTH-1:0]  resp_rd,
    output logic                  resp_store,
    output logic [1:0]            resp_err,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int OFF_W = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

    state_t           state;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [OFF_W-1:0] off_q;
    logic             aw_done;
    logic             w_done;

    logic [OFF_W-1:0]      req_off;
    logic                  req_bad;
    logic [STRB_WIDTH-1:0] strb_base;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  sign_bit;
    int unsigned           nbits;

    // Request decode: lane offset, alignment/legality, strobe pattern
    always_comb begin
        req_off = req_addr[OFF_W-1:0];
        case (req_size)
            2'd0: req_bad = 1'b0;
            2'd1: req_bad = req_off[0];
            2'd2: req_bad = (req_off[1:0] != 2'b00);
            default: req_bad = (DATA_WIDTH == 32) || (req_off != '0);
        endcase
        case (req_size)
            2'd0: strb_base = STRB_WIDTH'(1);
            2'd1: strb_base = STRB_WIDTH'(3);
            2'd2: strb_base = STRB_WIDTH'(15);
            default: strb_base = '1;
        endcase
    end

    // Load data: shift the addressed lane down and sign/zero extend by size
    always_comb begin
        lane = rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0: begin nbits = 8;  sign_bit = lane[7];  end
            2'd1: begin nbits = 16; sign_bit = lane[15]; end
            2'd2: begin nbits = 32; sign_bit = lane[31]; end
            default: begin nbits = DATA_WIDTH; sign_bit = lane[DATA_WIDTH-1]; end
        endcase
        load_ext = lane;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (i >= nbits) load_ext[i] = ~uns_q & sign_bit;
        end
    end

    // Transaction FSM with registered handshake and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_store <= 1'b0;
            resp_err   <= 2'b00;
            awaddr     <= '0;
            awvalid    <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            size_q     <= 2'd0;
            uns_q      <= 1'b0;
            off_q      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        resp_rd    <= req_rd;
                        resp_store <= req_store;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        off_q      <= req_off;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 2'b01;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_store) begin
                            awaddr  <= req_addr;
                            awvalid <= 1'b1;
                            wdata   <= req_wdata << {req_off, 3'b000};
                            wstrb   <= strb_base << req_off;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= AW_W;
                        end else begin
                            araddr  <= req_addr;
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (rresp != 2'b00) begin
                            resp_err   <= 2'b10;
                            resp_rdata <= '0;
                        end else begin
                            resp_err   <= 2'b00;
                            resp_rdata <= load_ext;
                        end
                    end
                end
                AW_W: begin
                    // Channels complete independently; the done flags remember
                    // which handshake already happened so order does not matter.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready))) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= (bresp != 2'b00) ? 2'b10 : 2'b00;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Directed bench for the load/store unit: 32-bit and 64-bit instances
// driven by scripted AXI4-Lite slave behaviour.
module tb_ysyx_23060208_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance signals
    logic        req_valid = 0, req_ready, req_store = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [4:0]  req_rd = 0;
    logic        resp_valid, resp_ready = 0, resp_store;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, awready = 0, wvalid, wready = 0, bready, bvalid = 0;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = 0, rresp = 0;
    logic        arvalid, arready = 0, rvalid = 0, rready;
    logic [31:0] rdata = 0;

    // 64-bit instance signals
    logic        d_req_valid = 0, d_req_ready, d_req_store = 0, d_req_unsigned = 0;
    logic [1:0]  d_req_size = 0;
    logic [31:0] d_req_addr = 0;
    logic [63:0] d_req_wdata = 0;
    logic [4:0]  d_req_rd = 0;
    logic        d_resp_valid, d_resp_ready = 0, d_resp_store;
    logic [63:0] d_resp_rdata;
    logic [4:0]  d_resp_rd;
    logic [1:0]  d_resp_err;
    logic [31:0] d_awaddr, d_araddr;
    logic [63:0] d_wdata;
    logic        d_awvalid, d_awready = 0, d_wvalid, d_wready = 0, d_bready, d_bvalid = 0;
    logic [7:0]  d_wstrb;
    logic [1:0]  d_bresp = 0, d_rresp = 0;
    logic        d_arvalid, d_arready = 0, d_rvalid = 0, d_rready;
    logic [63:0] d_rdata = 0;

    ysyx_23060208_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_WIDTH(5)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_store(resp_store), .resp_err(resp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    ysyx_23060208_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_WIDTH(5)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_store(d_req_store),
        .req_size(d_req_size), .req_unsigned(d_req_unsigned), .req_addr(d_req_addr),
        .req_wdata(d_req_wdata), .req_rd(d_req_rd),
        .resp_valid(d_resp_valid), .resp_ready(d_resp_ready), .resp_rdata(d_resp_rdata),
        .resp_rd(d_resp_rd), .resp_store(d_resp_store), .resp_err(d_resp_err),
        .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
        .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
        .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready),
        .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
        .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue32(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd; req_valid = 1;
        tick();
        req_valid = 0;
    endtask

    // cycles from the accept edge until resp_valid, bounded
    task automatic wait_resp32(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_resp64(output int lat);
        lat = 1;
        while (!d_resp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_resp32();
        resp_ready = 1;
        tick();
        resp_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [31:0] held;
        tick(); tick();
        rst = 0;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready_bready", {rready, bready}, 0);
        check("rst_d_req_ready", d_req_ready, 1);

        // lb at offset 3, zero-wait slave
        arready = 1; rvalid = 1; rresp = 0; rdata = 32'h80AB_CDEF;
        issue32(0, 0, 0, 32'h8000_0003, 0, 5'd5);
        check("lb_arvalid", arvalid, 1);
        check("lb_araddr", araddr, 32'h8000_0003);
        wait_resp32(lat);
        check("lb_latency", lat, 3);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_err", resp_err, 0);
        check("lb_rd", resp_rd, 5);
        finish_resp32();
        check("lb_idle_ready", req_ready, 1);

        // lbu same access, then stall the response with a request pending
        issue32(0, 0, 1, 32'h8000_0003, 0, 5'd6);
        wait_resp32(lat);
        check("lbu_rdata", resp_rdata, 32'h0000_0080);
        req_store = 0; req_size = 1; req_unsigned = 1; req_addr = 32'h8000_0002; req_rd = 5'd7;
        req_valid = 1;
        held = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", resp_valid, 1);
            check("stall_rdata", resp_rdata, held);
            check("stall_req_ready", req_ready, 0);
        end
        resp_ready = 1;
        tick();
        resp_ready = 0;
        check("turn_resp_valid", resp_valid, 0);
        check("turn_req_ready", req_ready, 1);
        tick();
        req_valid = 0;
        check("turn_accepted", req_ready, 0);
        check("turn_arvalid", arvalid, 1);
        wait_resp32(lat);
        check("lhu_rdata", resp_rdata, 32'h0000_80AB);
        check("lhu_rd", resp_rd, 7);
        finish_resp32();
        arready = 0; rvalid = 0;

        // sh at offset 2, awready two cycles ahead of wready
        issue32(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 5'd0);
        check("sh_awaddr", awaddr, 32'h8000_0002);
        check("sh_wdata", wdata, 32'h1234_0000);
        check("sh_wstrb", wstrb, 4'b1100);
        check("sh_valids", {awvalid, wvalid}, 2'b11);
        awready = 1;
        tick();
        awready = 0;
        check("sh_aw_drop", {awvalid, wvalid, bready}, 3'b010);
        tick();
        check("sh_w_hold", {awvalid, wvalid, bready}, 3'b010);
        wready = 1;
        tick();
        wready = 0;
        check("sh_b_phase", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 0;
        tick();
        bvalid = 0;
        check("sh_resp_valid", resp_valid, 1);
        check("sh_resp", {resp_store, resp_err}, 3'b100);
        check("sh_resp_rdata", resp_rdata, 0);
        finish_resp32();

        // lw misaligned: no bus activity, error one cycle after accept
        issue32(0, 2, 0, 32'h8000_0001, 0, 5'd3);
        check("lw_mis_valid", resp_valid, 1);
        check("lw_mis_err", resp_err, 2'b01);
        check("lw_mis_arvalid", arvalid, 0);
        finish_resp32();
        check("lw_mis_arvalid_after", arvalid, 0);

        // sd is illegal on a 32-bit unit
        issue32(1, 3, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        check("sd32_err", {resp_valid, resp_err}, 3'b101);
        check("sd32_awvalid", {awvalid, wvalid}, 0);
        finish_resp32();

        // delayed arready, then error read response
        issue32(0, 2, 0, 32'h8000_0010, 0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            check("ar_wait_valid", arvalid, 1);
            check("ar_wait_addr", araddr, 32'h8000_0010);
            tick();
        end
        arready = 1;
        tick();
        arready = 0;
        check("ar_done", {arvalid, rready}, 2'b01);
        rvalid = 1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 0; rresp = 0;
        check("rerr_valid", resp_valid, 1);
        check("rerr_err", resp_err, 2'b10);
        check("rerr_rdata", resp_rdata, 0);
        finish_resp32();

        // 64-bit: ld at 0x...08 and lw from the upper word
        d_arready = 1; d_rvalid = 1; d_rdata = 64'h1122_3344_5566_7788;
        d_req_store = 0; d_req_size = 3; d_req_unsigned = 0; d_req_addr = 32'h8000_0008; d_req_rd = 5'd10;
        d_req_valid = 1;
        tick();
        d_req_valid = 0;
        wait_resp64(lat);
        check("ld64_latency", lat, 3);
        check("ld64_rdata", d_resp_rdata, 64'h1122_3344_5566_7788);
        check("ld64_err", d_resp_err, 0);
        d_resp_ready = 1; tick(); d_resp_ready = 0;
        d_req_size = 2; d_req_addr = 32'h8000_0004;
        d_req_valid = 1;
        tick();
        d_req_valid = 0;
        wait_resp64(lat);
        check("lw64_rdata", d_resp_rdata, 64'h0000_0000_1122_3344);
        d_resp_ready = 1; tick(); d_resp_ready = 0;
        d_arready = 0; d_rvalid = 0;

        // 64-bit: reset while in AW_W
        d_req_store = 1; d_req_size = 3; d_req_addr = 32'h8000_0010; d_req_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
        d_req_valid = 1;
        tick();
        d_req_valid = 0;
        check("sd64_valids", {d_awvalid, d_wvalid}, 2'b11);
        check("sd64_wstrb", d_wstrb, 8'hFF);
        rst = 1;
        tick();
        rst = 0;
        check("rst_mid_valids", {d_awvalid, d_wvalid, d_bready}, 0);
        check("rst_mid_ready", d_req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
